// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, sequencer states and per-opcode last execute state
package cpu_pkg;
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

  // ALU reg and immediate opcodes are contiguous, so one range covers both
  function automatic state_t last_state(input logic [4:0] op);
    return (op inside {[OP_ADD:OP_ORI]}) ? T5 :
           (op inside {OP_DIV, OP_MUL}) ? T6 :
           (op inside {OP_NEG, OP_NOT}) ? T4 :
           (op inside {OP_LD, OP_ST})   ? T7 : T3;
  endfunction
endpackage

// File: rtl/control_unit_select_encode.sv
// select_encode: picks Ra/Rb/Rc, decodes it one-hot onto Rin/Rout, sign-extends C
module select_encode (
  input  logic [26:0] ir,
  input  logic        gra,
  input  logic        grb,
  input  logic        grc,
  input  logic        rin,
  input  logic        rout,
  input  logic        ba_out,
  output logic [15:0] rin_vec,
  output logic [15:0] rout_vec,
  output logic [31:0] csext
);
  logic [3:0]  sel;
  logic [15:0] hot;
  assign sel      = gra ? ir[26:23] : grb ? ir[22:19] : ir[18:15];
  assign hot      = (gra | grb | grc) ? 16'd1 << sel : '0;
  assign rin_vec  = rin ? hot : '0;
  assign rout_vec = (rout | ba_out) ? hot : '0;
  assign csext    = {{13{ir[18]}}, ir[18:0]};
endmodule

// File: rtl/control_unit.sv
// control_unit: hard-wired fetch/execute sequencer driving datapath strobes from IR
module control_unit
  import cpu_pkg::*;
#(
  parameter int RESET_PC_HOLD = 1
) (
  input  logic        Clock,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        Run,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        BAout,
  output logic [31:0] Csext,
  output logic        Cout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        HIin,
  output logic        HIout,
  output logic        LOin,
  output logic        LOout,
  output logic        INPORTout,
  output logic        OUTPORTin
);
  state_t      state, state_n, last;
  logic [15:0] cnt;
  logic        hold_done;
  logic [4:0]  op;
  logic        alu, imm, un, md, mem;
  logic        gra, grb, grc, rin_s, rout_s;

  assign op        = IR[31:27];
  assign alu       = op inside {[OP_ADD:OP_SHL]};
  assign imm       = op inside {[OP_ADDI:OP_ORI]};
  assign un        = op inside {OP_NEG, OP_NOT};
  assign md        = op inside {OP_DIV, OP_MUL};
  assign mem       = op inside {OP_LD, OP_ST};
  assign last      = last_state(op);
  assign hold_done = {16'd0, cnt} + 32'd1 >= $unsigned(RESET_PC_HOLD);
  assign Run       = !(state inside {RST, HALT});

  always_ff @(posedge Clock)
    if (!clr) begin
      state <= RST;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state == RST) ? cnt + 16'd1 : '0;
    end

  always_comb begin
    state_n = state;
    case (state)
      RST:     state_n = hold_done ? T0 : RST;
      T0:      state_n = T1;
      T1:      state_n = T2;
      T2:      state_n = T3;
      HALT:    state_n = HALT;
      default: state_n = (state == last) ? ((Stop || op == OP_HALT) ? HALT : T0) : state_t'(state + 4'd1);
    endcase
  end

  always_comb begin
    {Cout, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin,
     ZLOout, ZHIout, HIin, HIout, LOin, LOout, INPORTout, OUTPORTin, BAout} = '0;
    {gra, grb, grc, rin_s, rout_s} = '0;
    case (state)
      T0: {PCout, MARin, IncPC, Zin} = '1;
      T1: {ZLOout, PCin, Read, MDRin} = '1;
      T2: {MDRout, IRin} = '1;
      T3:
        if (alu || imm) {grb, rout_s, Yin} = '1;
        else if (un) {grb, rout_s, Zin} = '1;
        else if (md) {gra, rout_s, Yin} = '1;
        else if (mem) {grb, BAout, Yin} = '1;
        else if (op == OP_MFHI) {HIout, gra, rin_s} = '1;
        else if (op == OP_MFLO) {LOout, gra, rin_s} = '1;
        else if (op == OP_IN) {INPORTout, gra, rin_s} = '1;
        else if (op == OP_OUT) {gra, rout_s, OUTPORTin} = '1;
        else if (op == OP_JR) {gra, rout_s, PCin} = '1;
      T4:
        if (alu) {grc, rout_s, Zin} = '1;
        else if (md) {grb, rout_s, Zin} = '1;
        else if (imm || mem) {Cout, Zin} = '1;
        else if (un) {ZLOout, gra, rin_s} = '1;
      T5:
        if (alu || imm) {ZLOout, gra, rin_s} = '1;
        else if (md) {ZLOout, LOin} = '1;
        else if (mem) {ZLOout, MARin} = '1;
      T6:
        if (md) {ZHIout, HIin} = '1;
        else if (op == OP_LD) {Read, MDRin} = '1;
        else if (op == OP_ST) {gra, rout_s, MDRin} = '1;
      T7:
        if (op == OP_LD) {MDRout, gra, rin_s} = '1;
        else if (op == OP_ST) Write = 1'b1;
      default: ;
    endcase
  end

  select_encode u_sel (
    .ir(IR[26:0]),
    .gra(gra),
    .grb(grb),
    .grc(grc),
    .rin(rin_s),
    .rout(rout_s),
    .ba_out(BAout),
    .rin_vec(Rin),
    .rout_vec(Rout),
    .csext(Csext)
  );
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench, expected per-cycle strobes queued from an opcode model
module tb_control_unit;
  localparam int HOLD = 2;
  localparam logic [20:0] COUT = 21'd1 << 20, PCOUT = 21'd1 << 19, PCIN = 21'd1 << 18,
    INCPC = 21'd1 << 17, MARIN = 21'd1 << 16, MDRIN = 21'd1 << 15, MDROUT = 21'd1 << 14,
    READ = 21'd1 << 13, WRITE = 21'd1 << 12, IRIN = 21'd1 << 11, YIN = 21'd1 << 10,
    ZIN = 21'd1 << 9, ZLOOUT = 21'd1 << 8, ZHIOUT = 21'd1 << 7, HIIN = 21'd1 << 6,
    HIOUT = 21'd1 << 5, LOIN = 21'd1 << 4, LOOUT = 21'd1 << 3, INPORTOUT = 21'd1 << 2,
    OUTPORTIN = 21'd1 << 1, BAOUT = 21'd1;

  typedef struct packed {
    logic [53:0] v;
    logic [31:0] c;
    logic        chk_c;
    logic        stop;
    logic        rst;
    logic [31:0] ir;
    logic [63:0] tag;
  } row_t;

  logic Clock = 0, clr = 0, Stop = 0;
  logic [31:0] IR = '0;
  logic Run, BAout, Cout, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin;
  logic ZLOout, ZHIout, HIin, HIout, LOin, LOout, INPORTout, OUTPORTin;
  logic [15:0] Rin, Rout;
  logic [31:0] Csext;
  logic [53:0] obs;
  row_t q[$];
  int errors = 0, checks = 0;
  bit mon = 0;

  always #5 Clock = ~Clock;

  control_unit #(.RESET_PC_HOLD(HOLD)) dut (
    .Clock(Clock), .clr(clr), .IR(IR), .Stop(Stop), .Run(Run), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .Csext(Csext), .Cout(Cout), .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .ZLOout(ZLOout), .ZHIout(ZHIout), .HIin(HIin), .HIout(HIout),
    .LOin(LOin), .LOout(LOout), .INPORTout(INPORTout), .OUTPORTin(OUTPORTin)
  );

  assign obs = {Cout, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin,
                ZLOout, ZHIout, HIin, HIout, LOin, LOout, INPORTout, OUTPORTin, BAout, Rin, Rout, Run};

  function automatic void add_row(input logic [31:0] ir, input logic [20:0] s, input logic [15:0] ri,
                                  input logic [15:0] ro, input logic run, input logic [63:0] tag);
    row_t r;
    r = '0;
    r.v = {s, ri, ro, run};
    r.ir = ir;
    r.tag = tag;
    q.push_back(r);
  endfunction

  function automatic void push_reset();
    for (int i = 0; i < HOLD; i++) add_row('0, '0, '0, '0, 1'b0, "rst");
  endfunction

  function automatic void push_instr(input logic [31:0] ir, input logic [63:0] tag, input logic stop_last);
    logic [4:0] op;
    logic [15:0] a, b, c;
    logic [31:0] cs;
    op = ir[31:27];
    a = 16'd1 << ir[26:23];
    b = 16'd1 << ir[22:19];
    c = 16'd1 << ir[18:15];
    cs = {{13{ir[18]}}, ir[18:0]};
    add_row(ir, PCOUT | MARIN | INCPC | ZIN, '0, '0, 1'b1, tag);
    add_row(ir, ZLOOUT | PCIN | READ | MDRIN, '0, '0, 1'b1, tag);
    add_row(ir, MDROUT | IRIN, '0, '0, 1'b1, tag);
    if (op inside {[5'b00011:5'b01011]}) begin
      add_row(ir, YIN, '0, b, 1'b1, tag);
      add_row(ir, ZIN, '0, c, 1'b1, tag);
      add_row(ir, ZLOOUT, a, '0, 1'b1, tag);
    end else if (op inside {[5'b01100:5'b01110]}) begin
      add_row(ir, YIN, '0, b, 1'b1, tag);
      add_row(ir, COUT | ZIN, '0, '0, 1'b1, tag);
      q[q.size()-1].chk_c = 1'b1;
      q[q.size()-1].c = cs;
      add_row(ir, ZLOOUT, a, '0, 1'b1, tag);
    end else if (op inside {5'b10001, 5'b10010}) begin
      add_row(ir, ZIN, '0, b, 1'b1, tag);
      add_row(ir, ZLOOUT, a, '0, 1'b1, tag);
    end else if (op inside {5'b01111, 5'b10000}) begin
      add_row(ir, YIN, '0, a, 1'b1, tag);
      add_row(ir, ZIN, '0, b, 1'b1, tag);
      add_row(ir, ZLOOUT | LOIN, '0, '0, 1'b1, tag);
      add_row(ir, ZHIOUT | HIIN, '0, '0, 1'b1, tag);
    end else if (op inside {5'b00000, 5'b00010}) begin
      add_row(ir, BAOUT | YIN, '0, b, 1'b1, tag);
      add_row(ir, COUT | ZIN, '0, '0, 1'b1, tag);
      q[q.size()-1].chk_c = 1'b1;
      q[q.size()-1].c = cs;
      add_row(ir, ZLOOUT | MARIN, '0, '0, 1'b1, tag);
      if (op == 5'b00000) begin
        add_row(ir, READ | MDRIN, '0, '0, 1'b1, tag);
        add_row(ir, MDROUT, a, '0, 1'b1, tag);
      end else begin
        add_row(ir, MDRIN, '0, a, 1'b1, tag);
        add_row(ir, WRITE, '0, '0, 1'b1, tag);
      end
    end else if (op == 5'b11000) add_row(ir, HIOUT, a, '0, 1'b1, tag);
    else if (op == 5'b11001) add_row(ir, LOOUT, a, '0, 1'b1, tag);
    else if (op == 5'b10110) add_row(ir, INPORTOUT, a, '0, 1'b1, tag);
    else if (op == 5'b10111) add_row(ir, OUTPORTIN, '0, a, 1'b1, tag);
    else if (op == 5'b10100) add_row(ir, PCIN, '0, a, 1'b1, tag);
    else add_row(ir, '0, '0, '0, 1'b1, tag);
    q[q.size()-1].stop = stop_last;
  endfunction

  always @(negedge Clock)
    if (mon) begin
      checks++;
      if ($countones({Cout, PCout, ZLOout, ZHIout, MDRout, HIout, LOout, INPORTout, BAout,
                      (Rout != 16'd0) && !BAout}) > 1 || $countones(Rin) > 1 || $countones(Rout) > 1) begin
        errors++;
        $display("FAIL bus_onehot at %0t: rin=%h rout=%h baout=%b, required <=1 driver and <=1 hot bit",
                 $time, Rin, Rout, BAout);
      end
    end

  task automatic test_reset();
    row_t e;
    add_row('0, '0, '0, '0, 1'b0, "reset");
    q[0].rst = 1'b1;
    push_reset();
    while (q.size() > 0) begin
      e = q.pop_front();
      IR = e.ir;
      @(negedge Clock);
      checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %h required %h", e.tag, obs, e.v); end
      Stop = e.stop;
      clr = !e.rst;
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic test_add();
    row_t e;
    push_instr(32'h18918000, "add", 1'b0);
    while (q.size() > 0) begin
      e = q.pop_front();
      IR = e.ir;
      @(negedge Clock);
      checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %h required %h", e.tag, obs, e.v); end
      Stop = e.stop;
      clr = !e.rst;
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic test_const_muldiv();
    row_t e;
    push_instr({5'b00000, 4'd2, 4'd0, 19'h00065}, "ld", 1'b0);
    push_instr({5'b01100, 4'd1, 4'd2, 19'h7FFFF}, "addi", 1'b0);
    push_instr({5'b10000, 4'd3, 4'd4, 19'd0}, "mul", 1'b0);
    while (q.size() > 0) begin
      e = q.pop_front();
      IR = e.ir;
      @(negedge Clock);
      checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %h required %h", e.tag, obs, e.v); end
      if (e.chk_c) begin
        checks++;
        if (Csext !== e.c) begin errors++; $display("FAIL %s csext: got %h required %h", e.tag, Csext, e.c); end
      end
      Stop = e.stop;
      clr = !e.rst;
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    row_t e;
    logic [31:0] prog [17];
    prog = '{{5'b00100, 4'd4, 4'd5, 4'd6, 15'd0}, {5'b00111, 4'd7, 4'd8, 4'd9, 15'd0},
             {5'b01011, 4'd15, 4'd0, 4'd14, 15'd0}, {5'b01101, 4'd10, 4'd11, 19'h40000},
             {5'b01110, 4'd0, 4'd1, 19'h00123}, {5'b10001, 4'd12, 4'd13, 19'd0},
             {5'b10010, 4'd14, 4'd15, 19'd0}, {5'b01111, 4'd5, 4'd6, 19'd0},
             {5'b00010, 4'd7, 4'd8, 19'h00010}, {5'b11000, 4'd9, 23'd0},
             {5'b11001, 4'd10, 23'd0}, {5'b10110, 4'd11, 23'd0}, {5'b10111, 4'd12, 23'd0},
             {5'b10100, 4'd13, 23'd0}, {5'b11010, 27'd0}, {5'b00001, 4'd3, 23'd0},
             {5'b11111, 4'd4, 23'd0}};
    foreach (prog[i]) push_instr(prog[i], "b2b", 1'b0);
    while (q.size() > 0) begin
      e = q.pop_front();
      IR = e.ir;
      @(negedge Clock);
      checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s ir=%h: got %h required %h", e.tag, e.ir, obs, e.v); end
      if (e.chk_c) begin
        checks++;
        if (Csext !== e.c) begin errors++; $display("FAIL %s csext: got %h required %h", e.tag, Csext, e.c); end
      end
      Stop = e.stop;
      clr = !e.rst;
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic test_halt();
    row_t e;
    push_instr({5'b11011, 27'd0}, "haltop", 1'b0);
    for (int i = 0; i < 3; i++) add_row('0, '0, '0, '0, 1'b0, "haltst");
    q[q.size()-1].rst = 1'b1;
    push_reset();
    push_instr(32'h18918000, "stop_t4", 1'b0);
    q[q.size()-2].stop = 1'b1;
    push_instr(32'h18918000, "stop_t5", 1'b1);
    for (int i = 0; i < 20; i++) add_row(32'h18918000, '0, '0, '0, 1'b0, "halted");
    q[q.size()-1].rst = 1'b1;
    push_reset();
    while (q.size() > 0) begin
      e = q.pop_front();
      IR = e.ir;
      @(negedge Clock);
      checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %h required %h", e.tag, obs, e.v); end
      Stop = e.stop;
      clr = !e.rst;
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic test_abort();
    row_t e;
    push_instr({5'b00010, 4'd5, 4'd6, 19'h00010}, "st_abort", 1'b0);
    void'(q.pop_back());
    q[q.size()-1].rst = 1'b1;
    push_reset();
    push_instr({5'b11010, 27'd0}, "nop", 1'b0);
    while (q.size() > 0) begin
      e = q.pop_front();
      IR = e.ir;
      @(negedge Clock);
      checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %h required %h", e.tag, obs, e.v); end
      Stop = e.stop;
      clr = !e.rst;
      @(posedge Clock);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, required completion before %0t", $time);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge Clock);
    #1;
    mon = 1;
    test_reset();
    test_add();
    test_const_muldiv();
    test_back_to_back();
    test_halt();
    test_abort();
    mon = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
